// File: rtl/risc16_mem_pkg.sv
// Shared types and constants for the program/data RAM port arbiter.
package risc16_mem_pkg;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 16;

   // Wait counter width; holds WAIT_CYC-1 for WAIT_CYC in 1..7.
   localparam int unsigned CNT_W  = 3;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACK    = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; req[0] is the CPU, req[1] is the debug master.
module rr_arb2
   import risc16_mem_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_owner,
   output logic       o_grant_valid_c,
   output logic       o_grant_id_c
);

   // On a tie, the master that did not own the last access wins.
   always_comb begin
      o_grant_valid_c = |i_req;
      o_grant_id_c    = OWN_CPU;
      if (i_req == 2'b11) begin
         o_grant_id_c = ~i_last_owner;
      end else if (i_req[1]) begin
         o_grant_id_c = OWN_DBG;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between the CPU and the debug/loader
// master and sequences each access: address phase, read wait, capture, ack.
module mem_port_arbiter
   import risc16_mem_pkg::*;
#(
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned WAIT_CYC = 1
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner,
   output logic          busy
);

   arb_state_t       r_state;
   logic             r_last_owner;
   logic             r_owner;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [DW-1:0]    r_wdata;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mem_en;
   logic             r_mem_we;
   logic             r_cpu_ack;
   logic             r_dbg_ack;
   logic [DW-1:0]    r_cpu_rdata;
   logic [DW-1:0]    r_dbg_rdata;
   logic             r_busy;

   logic             w_grant_valid;
   logic             w_grant_id;
   logic             w_sel_we;
   logic [AW-1:0]    w_sel_addr;
   logic [DW-1:0]    w_sel_wdata;

   rr_arb2 u_rr_arb2 (
      .i_req           ({dbg_req, cpu_req}),
      .i_last_owner    (r_last_owner),
      .o_grant_valid_c (w_grant_valid),
      .o_grant_id_c    (w_grant_id)
   );

   // Access fields of whichever master the picker selects this cycle.
   assign w_sel_we    = (w_grant_id == OWN_DBG) ? dbg_we    : cpu_we;
   assign w_sel_addr  = (w_grant_id == OWN_DBG) ? dbg_addr  : cpu_addr;
   assign w_sel_wdata = (w_grant_id == OWN_DBG) ? dbg_wdata : cpu_wdata;

   // Access sequencer; strobes and acks are registered so they line up with the state they belong to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_last_owner <= OWN_DBG;
         r_owner      <= OWN_CPU;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_dbg_ack    <= 1'b0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_mem_en  <= 1'b0;
         r_mem_we  <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_dbg_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  r_owner  <= w_grant_id;
                  r_we     <= w_sel_we;
                  r_addr   <= w_sel_addr;
                  r_wdata  <= w_sel_wdata;
                  r_mem_en <= 1'b1;
                  r_mem_we <= w_sel_we;
                  r_busy   <= 1'b1;
                  r_state  <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (r_we) begin
                  if (r_owner == OWN_DBG) r_dbg_ack <= 1'b1;
                  else                    r_cpu_ack <= 1'b1;
                  r_state <= ST_ACK;
               end else begin
                  r_cnt   <= CNT_W'(WAIT_CYC - 1);
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  if (r_owner == OWN_DBG) begin
                     r_dbg_rdata <= mem_rdata;
                     r_dbg_ack   <= 1'b1;
                  end else begin
                     r_cpu_rdata <= mem_rdata;
                     r_cpu_ack   <= 1'b1;
                  end
                  r_state <= ST_ACK;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_ACK: begin
               r_last_owner <= r_owner;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata = r_cpu_rdata;
   assign cpu_ack   = r_cpu_ack;
   assign dbg_rdata = r_dbg_rdata;
   assign dbg_ack   = r_dbg_ack;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign owner     = r_owner;
   assign busy      = r_busy;

   // CPU sequencer hold: pending request not yet acknowledged.
   assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at WAIT_CYC=1, one at WAIT_CYC=3.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset;

   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [7:0]  cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata;
   logic [15:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic        cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, owner, busy;
   logic [7:0]  mem_addr;

   logic        d3_dbg_req;
   logic [7:0]  d3_dbg_addr;
   logic [15:0] d3_cpu_rdata, d3_dbg_rdata, d3_mem_wdata, d3_mem_rdata;
   logic        d3_cpu_ack, d3_cpu_stall, d3_dbg_ack, d3_mem_en, d3_mem_we, d3_owner, d3_busy;
   logic [7:0]  d3_mem_addr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(8), .DW(16), .WAIT_CYC(1)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
   );

   mem_port_arbiter #(.AW(8), .DW(16), .WAIT_CYC(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(8'h00), .cpu_wdata(16'h0000),
      .cpu_rdata(d3_cpu_rdata), .cpu_ack(d3_cpu_ack), .cpu_stall(d3_cpu_stall),
      .dbg_req(d3_dbg_req), .dbg_we(1'b0), .dbg_addr(d3_dbg_addr), .dbg_wdata(16'h0000),
      .dbg_rdata(d3_dbg_rdata), .dbg_ack(d3_dbg_ack),
      .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
      .mem_rdata(d3_mem_rdata), .owner(d3_owner), .busy(d3_busy)
   );

   // RAM models: read data is valid only WAIT_CYC cycles after the mem_en cycle, 16'hDEAD otherwise.
   logic [15:0] ram1 [0:255];
   logic [15:0] ram3 [0:255];
   logic [15:0] p1_d;
   logic        p1_v = 1'b0;
   logic [15:0] p3_d [0:2];
   logic        p3_v [0:2];

   always @(posedge clk) begin
      if (mem_en && mem_we) ram1[mem_addr] <= mem_wdata;
      p1_v <= mem_en && !mem_we;
      p1_d <= ram1[mem_addr];
   end
   assign mem_rdata = p1_v ? p1_d : 16'hDEAD;

   always @(posedge clk) begin
      if (d3_mem_en && d3_mem_we) ram3[d3_mem_addr] <= d3_mem_wdata;
      p3_v[0] <= d3_mem_en && !d3_mem_we;
      p3_d[0] <= ram3[d3_mem_addr];
      p3_v[1] <= p3_v[0];
      p3_d[1] <= p3_d[0];
      p3_v[2] <= p3_v[1];
      p3_d[2] <= p3_d[1];
   end
   assign d3_mem_rdata = p3_v[2] ? p3_d[2] : 16'hDEAD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ci, di, n_acks, en_cnt;
      logic pc, pd;

      for (int i = 0; i < 256; i++) begin
         ram1[i] = 16'h0000;
         ram3[i] = 16'h0000;
      end
      for (int i = 0; i < 3; i++) p3_v[i] = 1'b0;
      ram1[8'h05] = 16'h1234;
      for (int i = 0; i < 4; i++) begin
         ram1[8'h20 + i] = 16'hC100 + 16'(i);
         ram1[8'h30 + i] = 16'hD200 + 16'(i);
      end
      ram3[8'h7F] = 16'hA5A5;

      // Reset held with both masters requesting; CPU read 0x05 and debug write 0x10 pending.
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05; cpu_wdata = 16'h0000;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 16'hBEEF;
      d3_dbg_req = 1'b0; d3_dbg_addr = 8'h00;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_mem_en", mem_en, 0);
         chk("rst_outs", {mem_we, cpu_ack, dbg_ack, owner, busy}, 0);
         chk("rst_buses", {mem_addr, mem_wdata}, 0);
         chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
      end
      chk("rst_d3", {d3_mem_en, d3_busy, d3_dbg_ack, d3_cpu_ack, d3_cpu_rdata, d3_dbg_rdata}, 0);

      // CPU wins the first tie; read of 0x05 with one wait cycle.
      reset = 1'b1;
      #1 chk("t2_c0_stall", cpu_stall, 1);
      tick();
      chk("t2_c1_mem_en", mem_en, 1);
      chk("t2_c1_mem_we", mem_we, 0);
      chk("t2_c1_addr", mem_addr, 8'h05);
      chk("t2_c1_owner", owner, 0);
      chk("t2_c1_busy", busy, 1);
      chk("t2_c1_stall", cpu_stall, 1);
      tick();
      chk("t2_c2_mem_en", mem_en, 0);
      chk("t2_c2_ack", cpu_ack, 0);
      chk("t2_c2_stall", cpu_stall, 1);
      tick();
      chk("t2_c3_ack", cpu_ack, 1);
      chk("t2_c3_rdata", cpu_rdata, 16'h1234);
      chk("t2_c3_stall", cpu_stall, 0);
      chk("t2_c3_dbg_ack", dbg_ack, 0);
      tick();
      chk("t2_c4_ack_off", cpu_ack, 0);
      chk("t2_c4_busy", busy, 0);
      chk("t2_c4_rdata_hold", cpu_rdata, 16'h1234);
      cpu_req = 1'b0;

      // Pending debug write of 0xBEEF to 0x10.
      tick();
      chk("t3_d1_strobes", {mem_en, mem_we}, 2'b11);
      chk("t3_d1_addr", mem_addr, 8'h10);
      chk("t3_d1_wdata", mem_wdata, 16'hBEEF);
      chk("t3_d1_owner", owner, 1);
      tick();
      chk("t3_d2_dbg_ack", dbg_ack, 1);
      chk("t3_d2_strobes", {mem_en, mem_we}, 0);
      chk("t3_d2_cpu_ack", cpu_ack, 0);
      chk("t3_d2_cpu_rdata", cpu_rdata, 16'h1234);
      chk("t3_d2_addr_hold", mem_addr, 8'h10);
      tick();
      dbg_req = 1'b0;
      cpu_addr = 8'h10; cpu_req = 1'b1;
      tick();
      chk("t3_rd_addr", mem_addr, 8'h10);
      tick();
      chk("t3_rd_c2_ack", cpu_ack, 0);
      tick();
      chk("t3_rd_c3_ack", cpu_ack, 1);
      chk("t3_rd_rdata", cpu_rdata, 16'hBEEF);
      tick();
      cpu_req = 1'b0;

      // Fresh reset so the CPU wins the tie, then four back-to-back reads per master.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      cpu_addr = 8'h20; dbg_addr = 8'h30; dbg_we = 1'b0;
      cpu_req = 1'b1; dbg_req = 1'b1;
      ci = 0; di = 0; n_acks = 0; pc = 1'b0; pd = 1'b0;
      for (int cyc = 0; cyc < 120 && n_acks < 8; cyc++) begin
         tick();
         if (pc) begin
            ci++; pc = 1'b0;
            if (ci == 4) cpu_req = 1'b0;
            else cpu_addr = 8'h20 + 8'(ci);
         end
         if (pd) begin
            di++; pd = 1'b0;
            if (di == 4) dbg_req = 1'b0;
            else dbg_addr = 8'h30 + 8'(di);
         end
         if (cpu_ack || dbg_ack) begin
            chk("t4_grant_order", {cpu_ack, dbg_ack}, (n_acks % 2 == 0) ? 2'b10 : 2'b01);
            if (cpu_ack) begin
               chk("t4_cpu_rdata", cpu_rdata, 16'hC100 + 16'(ci));
               pc = 1'b1;
            end
            if (dbg_ack) begin
               chk("t4_dbg_rdata", dbg_rdata, 16'hD200 + 16'(di));
               pd = 1'b1;
            end
            n_acks++;
         end
      end
      chk("t4_ack_count", n_acks, 8);
      tick();
      cpu_req = 1'b0; dbg_req = 1'b0;
      tick();

      // Reset asserted while a CPU read sits in WAIT.
      cpu_addr = 8'h05; cpu_we = 1'b0; cpu_req = 1'b1;
      tick();
      tick();
      chk("t5_in_wait_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("t5_async_busy", busy, 0);
      chk("t5_async_strobes", {mem_en, mem_we, cpu_ack, dbg_ack}, 0);
      chk("t5_async_rdata", {cpu_rdata, dbg_rdata}, 0);
      chk("t5_async_addr", mem_addr, 0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("t5_hold_quiet", {mem_en, cpu_ack}, 0);
      end
      cpu_addr = 8'h10;
      reset = 1'b1;
      tick();
      chk("t5_re_mem_en", mem_en, 1);
      chk("t5_re_addr", mem_addr, 8'h10);
      tick();
      chk("t5_re_c2_ack", cpu_ack, 0);
      tick();
      chk("t5_re_c3_ack", cpu_ack, 1);
      chk("t5_re_rdata", cpu_rdata, 16'hBEEF);
      tick();
      cpu_req = 1'b0;

      // Three-wait-cycle instance: debug read of 0x7F.
      d3_dbg_addr = 8'h7F; d3_dbg_req = 1'b1;
      en_cnt = 0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         en_cnt += int'(d3_mem_en);
         if (c < 5) chk("t6_no_early_ack", d3_dbg_ack, 0);
      end
      chk("t6_c5_ack", d3_dbg_ack, 1);
      chk("t6_rdata", d3_dbg_rdata, 16'hA5A5);
      chk("t6_en_pulses", en_cnt, 1);
      chk("t6_cpu_ack", d3_cpu_ack, 0);
      tick();
      d3_dbg_req = 1'b0;
      chk("t6_ack_off", d3_dbg_ack, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
